mem_port_sequencer: RTL

- Sequences the core's single shared memory port between instruction fetch and data load/store.
- Sits between the decoder/datapath (memread, memwrite, suspend) and the external memory bus.
- Holds the core stalled until each access completes, and flags bus timeouts.
- Exactly one outstanding transaction at a time; data access has priority over fetch.

---
 rtl/mem_port_sequencer_pkg.sv | 22 ++
 rtl/mem_timeout_ctr.sv | 43 ++++
 rtl/mem_port_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sequencer_pkg.sv
// mem_port_sequencer_pkg
//   Shared definitions for the memory port sequencer: the sequencer state
//   encoding and the byte-strobe width helper used to size store strobes.
package mem_port_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_RSP,
    F_REQ,
    F_RSP,
    HALT
  } seq_state_t;

  localparam int unsigned BYTE_W = 8;

  // Number of byte strobes for a data bus of width dw.
  function automatic int unsigned strb_width(input int unsigned dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr
//   Load-clear cycle counter with a terminal-count flag, for bus masters that
//   must give up on a request after LIMIT cycles of waiting.
//   Ports:
//     clk, resetn : clock, asynchronous active-low reset
//     clr         : clear the count to zero (takes priority over en)
//     en          : count this cycle
//     tc          : high during the LIMIT-th consecutive enabled cycle
//                   since the last clear; never high when LIMIT == 0
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CW    = (LIMIT < 2) ? 1 : $clog2(LIMIT)
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // The owner clears on tc, so count never exceeds LIMIT-1 and fits CW bits.
  always_comb begin
    tc = 1'b0;
    if (LIMIT != 0) begin
      tc = en && (count == LAST);
    end
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer
//   Shares a single memory port between instruction fetch and data
//   load/store. One transaction is outstanding at a time; data accesses win
//   over fetches. The core is stalled while an access is in flight, and a
//   grant/response that never arrives sets a sticky bus_err.
//   Ports:
//     clk, resetn                    : clock, asynchronous active-low reset
//     if_req, if_addr                : fetch request and address (PC)
//     if_rdata, if_valid             : fetched word, one-cycle valid pulse
//     memread, memwrite, suspend     : decoder controls, sampled in IDLE only
//     d_addr, d_wdata, d_wstrb       : load/store address, data, byte enables
//     d_rdata, d_valid               : load data, load/store completion pulse
//     stall                          : freeze PC/pipeline (combinational)
//     bus_err                        : sticky timeout flag, cleared by reset
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_wstrb           : registered bus request
//     mem_gnt, mem_rvalid, mem_rdata : bus grant, response and read data
module mem_port_sequencer
  import mem_port_sequencer_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      resetn,

  input  logic                      if_req,
  input  logic [AW-1:0]             if_addr,
  output logic [DW-1:0]             if_rdata,
  output logic                      if_valid,

  input  logic                      memread,
  input  logic                      memwrite,
  input  logic                      suspend,
  input  logic [AW-1:0]             d_addr,
  input  logic [DW-1:0]             d_wdata,
  input  logic [strb_width(DW)-1:0] d_wstrb,
  output logic [DW-1:0]             d_rdata,
  output logic                      d_valid,

  output logic                      stall,
  output logic                      bus_err,

  output logic                      mem_req,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  output logic [strb_width(DW)-1:0] mem_wstrb,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DW-1:0]             mem_rdata
);

  seq_state_t state;

  logic busy;
  logic in_req;
  logic in_rsp;
  logic leave;
  logic tmo_clr;
  logic tmo_hit;
  logic done_pulse;

  always_comb begin
    in_req     = (state == D_REQ) || (state == F_REQ);
    in_rsp     = (state == D_RSP) || (state == F_RSP);
    busy       = in_req || in_rsp;
    leave      = (in_req && mem_gnt) || (in_rsp && mem_rvalid);
    // Counter restarts on every state change, including a timeout exit.
    tmo_clr    = !busy || leave || tmo_hit;
    done_pulse = d_valid || if_valid;
  end

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (tmo_clr),
    .en     (busy),
    .tc     (tmo_hit)
  );

  // The core advances on the edge that ends a valid pulse, so it releases
  // stall in that cycle even if its request lines are still high.
  always_comb begin
    stall = 1'b0;
    if (!done_pulse) begin
      stall = (state != IDLE) || memread || memwrite || if_req;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      d_valid  <= 1'b0;
      if_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          // Decoder inputs still describe the completing instruction during a
          // valid pulse; wait one cycle so the next request sees updated ones.
          if (!done_pulse) begin
            if (memread || memwrite) begin
              state    <= D_REQ;
              mem_req  <= 1'b1;
              mem_addr <= d_addr;
              if (memwrite) begin
                mem_we    <= 1'b1;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
              end else begin
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
              end
            end else if (suspend) begin
              state <= HALT;
            end else if (if_req) begin
              state     <= F_REQ;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end
          end
        end

        D_REQ, F_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_rvalid) begin
              // Grant and response together: complete without visiting *_RSP.
              state <= IDLE;
              if (state == D_REQ) begin
                d_valid <= 1'b1;
                if (!mem_we) begin
                  d_rdata <= mem_rdata;
                end
              end else begin
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
              end
            end else begin
              state <= (state == D_REQ) ? D_RSP : F_RSP;
            end
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end
        end

        D_RSP, F_RSP: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (state == D_RSP) begin
              d_valid <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (tmo_hit) begin
            bus_err <= 1'b1;
            state   <= IDLE;
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
